// File: rtl/axis_frame_pkg.sv
// Shared AXI-Stream framing constants used by the frame FIFO, the coprocessor and its bench.
package axis_frame_pkg;

   localparam int AXIS_DATA_WIDTH = 32;
   localparam int AXIS_DEPTH      = 16;
   localparam int AXIS_FRAME_LEN  = 12;

   // A one-word frame still needs a 1-bit index register.
   function automatic int idx_width(input int frame_len);
      return (frame_len > 1) ? $clog2(frame_len) : 1;
   endfunction

endpackage

// File: rtl/axis_frame_fifo_mem.sv
// FIFO storage: one synchronous write port and an asynchronous read port, no reset on contents.
module axis_frame_fifo_mem #(
   parameter  int WIDTH = 33,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             ACLK,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge ACLK) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_frame_fifo.sv
// First-word fall-through AXI-Stream FIFO that regenerates TLAST from a word count and flags misaligned input TLAST.
module axis_frame_fifo
   import axis_frame_pkg::*;
#(
   parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
   parameter int DEPTH      = AXIS_DEPTH,
   parameter int FRAME_LEN  = AXIS_FRAME_LEN
) (
   input  logic                       ACLK,
   input  logic                       ARESETN,
   output logic                       S_AXIS_TREADY,
   input  logic [DATA_WIDTH-1:0]      S_AXIS_TDATA,
   input  logic                       S_AXIS_TLAST,
   input  logic                       S_AXIS_TVALID,
   output logic                       M_AXIS_TVALID,
   output logic [DATA_WIDTH-1:0]      M_AXIS_TDATA,
   output logic                       M_AXIS_TLAST,
   input  logic                       M_AXIS_TREADY,
   output logic                       FRAME_ERR,
   output logic [15:0]                FRAME_CNT,
   output logic [$clog2(DEPTH):0]     FIFO_COUNT
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = idx_width(FRAME_LEN);

   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [CW-1:0]       count;
   logic [IW-1:0]       in_idx;
   logic                frame_err;
   logic [15:0]         frame_cnt;
   logic                full;
   logic                empty;
   logic                wr_en;
   logic                rd_en;
   logic                idx_last;
   logic [DATA_WIDTH:0] head;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // Handshakes are gated by reset so both sides see an idle FIFO while ARESETN is low.
   assign S_AXIS_TREADY = ARESETN && !full;
   assign M_AXIS_TVALID = ARESETN && !empty;

   assign wr_en    = S_AXIS_TVALID && S_AXIS_TREADY;
   assign rd_en    = M_AXIS_TVALID && M_AXIS_TREADY;
   assign idx_last = (in_idx == IW'(FRAME_LEN - 1));

   axis_frame_fifo_mem #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (DEPTH)
   ) u_mem (
      .ACLK    (ACLK),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data ({idx_last, S_AXIS_TDATA}),
      .rd_addr (rd_ptr),
      .rd_data (head)
   );

   // Stale storage is masked so nothing leaks out while the FIFO is empty.
   assign M_AXIS_TDATA = M_AXIS_TVALID ? head[DATA_WIDTH-1:0] : '0;
   assign M_AXIS_TLAST = M_AXIS_TVALID && head[DATA_WIDTH];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Framing follows the word count only; a bad input TLAST is recorded but never resyncs in_idx.
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         in_idx    <= '0;
         frame_err <= 1'b0;
      end else if (wr_en) begin
         in_idx <= idx_last ? '0 : in_idx + IW'(1);
         if (S_AXIS_TLAST != idx_last) begin
            frame_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         frame_cnt <= '0;
      end else if (rd_en && head[DATA_WIDTH]) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end

   assign FRAME_ERR  = frame_err;
   assign FRAME_CNT  = frame_cnt;
   assign FIFO_COUNT = count;

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Directed bench for axis_frame_fifo: a vector table for reset and the first frame, then hand sequences.
module tb_axis_frame_fifo;
   import axis_frame_pkg::*;

   localparam int DW = AXIS_DATA_WIDTH;
   localparam int CW = $clog2(AXIS_DEPTH) + 1;

   logic          ACLK = 1'b0;
   logic          ARESETN;
   logic          S_AXIS_TREADY;
   logic [DW-1:0] S_AXIS_TDATA;
   logic          S_AXIS_TLAST;
   logic          S_AXIS_TVALID;
   logic          M_AXIS_TVALID;
   logic [DW-1:0] M_AXIS_TDATA;
   logic          M_AXIS_TLAST;
   logic          M_AXIS_TREADY;
   logic          FRAME_ERR;
   logic [15:0]   FRAME_CNT;
   logic [CW-1:0] FIFO_COUNT;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        rstn;
      logic        sv;
      logic [31:0] sd;
      logic        sl;
      logic        mr;
      logic        e_tready;
      logic        e_tvalid;
      logic [31:0] e_data;
      logic        e_last;
      int          e_count;
      int          e_cnt;
      logic        e_err;
   } vec_t;

   vec_t vecs[16];

   axis_frame_fifo dut (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .S_AXIS_TREADY (S_AXIS_TREADY),
      .S_AXIS_TDATA  (S_AXIS_TDATA),
      .S_AXIS_TLAST  (S_AXIS_TLAST),
      .S_AXIS_TVALID (S_AXIS_TVALID),
      .M_AXIS_TVALID (M_AXIS_TVALID),
      .M_AXIS_TDATA  (M_AXIS_TDATA),
      .M_AXIS_TLAST  (M_AXIS_TLAST),
      .M_AXIS_TREADY (M_AXIS_TREADY),
      .FRAME_ERR     (FRAME_ERR),
      .FRAME_CNT     (FRAME_CNT),
      .FIFO_COUNT    (FIFO_COUNT)
   );

   always #5 ACLK = ~ACLK;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic rstn, input logic sv, input logic [31:0] sd,
                                input logic sl, input logic mr);
      ARESETN       = rstn;
      S_AXIS_TVALID = sv;
      S_AXIS_TDATA  = sd;
      S_AXIS_TLAST  = sl;
      M_AXIS_TREADY = mr;
   endtask

   task automatic nextCycle();
      @(posedge ACLK);
      #1;
   endtask

   function automatic vec_t mk(input logic rstn, input logic sv, input logic [31:0] sd, input logic sl,
                               input logic mr, input logic tr, input logic tv, input logic [31:0] d,
                               input logic l, input int c, input int fc, input logic e);
      vec_t v;
      v.rstn = rstn; v.sv = sv; v.sd = sd; v.sl = sl; v.mr = mr;
      v.e_tready = tr; v.e_tvalid = tv; v.e_data = d; v.e_last = l;
      v.e_count = c; v.e_cnt = fc; v.e_err = e;
      return v;
   endfunction

   // Streams one 12-word frame with M_AXIS_TREADY=1; input TLAST goes on word tlast_pos (0 = none).
   task automatic streamFrame(input logic [31:0] base, input int tlast_pos, input logic err_in, input int cnt_in);
      int bad;
      bad = (tlast_pos >= 1 && tlast_pos < 12) ? tlast_pos : 12;
      for (int k = 1; k <= 13; k++) begin
         applyStimulus(1'b1, k <= 12, base + 32'(k), k == tlast_pos, 1'b1);
         @(negedge ACLK);
         checkOutput("stream_tvalid", 32'(M_AXIS_TVALID), 32'(k >= 2));
         if (k >= 2) begin
            checkOutput("stream_data", M_AXIS_TDATA, base + 32'(k - 1));
            checkOutput("stream_tlast", 32'(M_AXIS_TLAST), 32'(k == 13));
         end
         checkOutput("stream_err", 32'(FRAME_ERR), 32'(err_in || (tlast_pos != 12 && k > bad)));
         nextCycle();
      end
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge ACLK);
      checkOutput("stream_idle_tvalid", 32'(M_AXIS_TVALID), 32'h0);
      checkOutput("stream_frame_cnt", 32'(FRAME_CNT), 32'(cnt_in + 1));
      nextCycle();
   endtask

   initial begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      nextCycle();
      nextCycle();

      vecs[0]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
      vecs[1]  = mk(1, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 12; k++) begin
         vecs[k + 1] = mk(1, 1, 32'(k), k == 12, 1,
                          1, k >= 2, (k >= 2) ? 32'(k - 1) : 32'h0, 0, (k >= 2) ? 1 : 0, 0, 0);
      end
      vecs[14] = mk(1, 0, 0, 0, 1,  1, 1, 32'h0C, 1, 1, 0, 0);
      vecs[15] = mk(1, 0, 0, 0, 1,  1, 0, 0, 0, 0, 1, 0);

      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecs[i].rstn, vecs[i].sv, vecs[i].sd, vecs[i].sl, vecs[i].mr);
         @(negedge ACLK);
         checkOutput("vec_tready", 32'(S_AXIS_TREADY), 32'(vecs[i].e_tready));
         checkOutput("vec_tvalid", 32'(M_AXIS_TVALID), 32'(vecs[i].e_tvalid));
         if (vecs[i].e_tvalid || !vecs[i].rstn) begin
            checkOutput("vec_data", M_AXIS_TDATA, vecs[i].e_data);
            checkOutput("vec_tlast", 32'(M_AXIS_TLAST), 32'(vecs[i].e_last));
         end
         checkOutput("vec_count", 32'(FIFO_COUNT), 32'(vecs[i].e_count));
         checkOutput("vec_frame_cnt", 32'(FRAME_CNT), 32'(vecs[i].e_cnt));
         checkOutput("vec_frame_err", 32'(FRAME_ERR), 32'(vecs[i].e_err));
         nextCycle();
      end

      // Fill with the sink stalled: 16 of 20 words accepted, head held stable.
      for (int i = 1; i <= 20; i++) begin
         applyStimulus(1'b1, 1'b1, 32'(i), i == 12, 1'b0);
         @(negedge ACLK);
         checkOutput("full_tready", 32'(S_AXIS_TREADY), 32'(i <= 16));
         checkOutput("full_count", 32'(FIFO_COUNT), 32'((i - 1 > 16) ? 16 : i - 1));
         if (i >= 2) checkOutput("full_hold_data", M_AXIS_TDATA, 32'h1);
         nextCycle();
      end
      for (int j = 1; j <= 16; j++) begin
         applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
         @(negedge ACLK);
         checkOutput("drain_tready", 32'(S_AXIS_TREADY), 32'(j > 1));
         checkOutput("drain_tvalid", 32'(M_AXIS_TVALID), 32'h1);
         checkOutput("drain_data", M_AXIS_TDATA, 32'(j));
         checkOutput("drain_tlast", 32'(M_AXIS_TLAST), 32'(j == 12));
         checkOutput("drain_count", 32'(FIFO_COUNT), 32'(17 - j));
         nextCycle();
      end
      @(negedge ACLK);
      checkOutput("drain_end_count", 32'(FIFO_COUNT), 32'h0);
      checkOutput("drain_frame_cnt", 32'(FRAME_CNT), 32'h2);
      nextCycle();

      // Realign framing with a 2-cycle reset.
      for (int r = 0; r < 2; r++) begin
         applyStimulus(1'b0, 1'b1, 32'hFF, 1'b0, 1'b1);
         @(negedge ACLK);
         checkOutput("rst_tready", 32'(S_AXIS_TREADY), 32'h0);
         checkOutput("rst_tvalid", 32'(M_AXIS_TVALID), 32'h0);
         nextCycle();
      end
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge ACLK);
      checkOutput("rst_count", 32'(FIFO_COUNT), 32'h0);
      checkOutput("rst_frame_cnt", 32'(FRAME_CNT), 32'h0);
      checkOutput("rst_tready_after", 32'(S_AXIS_TREADY), 32'h1);
      nextCycle();

      streamFrame(32'h20, 5, 1'b0, 0);
      streamFrame(32'h30, 12, 1'b1, 1);

      // Occupancy 8, then 10 cycles of simultaneous push/pop across the pointer wrap.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b1, 32'h41 + 32'(i), 1'b0, 1'b0);
         @(negedge ACLK);
         checkOutput("wrap_fill_count", 32'(FIFO_COUNT), 32'(i));
         nextCycle();
      end
      for (int c = 0; c < 10; c++) begin
         applyStimulus(1'b1, 1'b1, 32'h49 + 32'(c), c == 3, 1'b1);
         @(negedge ACLK);
         checkOutput("wrap_count", 32'(FIFO_COUNT), 32'h8);
         checkOutput("wrap_data", M_AXIS_TDATA, 32'h41 + 32'(c));
         checkOutput("wrap_tlast", 32'(M_AXIS_TLAST), 32'h0);
         nextCycle();
      end
      for (int d = 0; d < 8; d++) begin
         applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
         @(negedge ACLK);
         checkOutput("wrap_drain_data", M_AXIS_TDATA, 32'h4B + 32'(d));
         checkOutput("wrap_drain_tlast", 32'(M_AXIS_TLAST), 32'(d == 1));
         checkOutput("wrap_drain_count", 32'(FIFO_COUNT), 32'(8 - d));
         nextCycle();
      end
      @(negedge ACLK);
      checkOutput("wrap_frame_cnt", 32'(FRAME_CNT), 32'h3);
      checkOutput("wrap_err_sticky", 32'(FRAME_ERR), 32'h1);
      nextCycle();

      // Reset after 5 words of a frame discards them and restarts framing.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b1, 32'h61 + 32'(i), 1'b0, 1'b0);
         nextCycle();
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge ACLK);
      checkOutput("midrst_tvalid_in_reset", 32'(M_AXIS_TVALID), 32'h0);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge ACLK);
      checkOutput("midrst_tvalid", 32'(M_AXIS_TVALID), 32'h0);
      checkOutput("midrst_count", 32'(FIFO_COUNT), 32'h0);
      checkOutput("midrst_err", 32'(FRAME_ERR), 32'h0);
      checkOutput("midrst_frame_cnt", 32'(FRAME_CNT), 32'h0);
      nextCycle();
      streamFrame(32'h70, 12, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axis_frame_fifo.md
AXIS_FRAME_FIFO -- requirements
Module: axis_frame_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the AXI-Stream data width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, the FIFO capacity in words (power of two, at least 2).
REQ-003 SHALL have parameter FRAME_LEN, default 12, the words per frame expected by the downstream coprocessor.
REQ-004 SHALL have port ACLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port ARESETN, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port S_AXIS_TREADY, output, 1 bit: FIFO can accept a word.
REQ-007 SHALL have port S_AXIS_TDATA, input, DATA_WIDTH bits: upstream data.
REQ-008 SHALL have port S_AXIS_TLAST, input, 1 bit: upstream end-of-frame marker; checked only, never forwarded.
REQ-009 SHALL have port S_AXIS_TVALID, input, 1 bit: upstream data valid.
REQ-010 SHALL have port M_AXIS_TVALID, output, 1 bit: head word is valid.
REQ-011 SHALL have port M_AXIS_TDATA, output, DATA_WIDTH bits: head word.
REQ-012 SHALL have port M_AXIS_TLAST, output, 1 bit: regenerated end-of-frame marker.
REQ-013 SHALL have port M_AXIS_TREADY, input, 1 bit: coprocessor accepts the head word.
REQ-014 SHALL have port FRAME_ERR, output, 1 bit: sticky upstream TLAST misalignment flag.
REQ-015 SHALL have port FRAME_CNT, output, 16 bits: count of frames delivered downstream, wrapping.
REQ-016 SHALL have port FIFO_COUNT, output, clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-017 SHALL drive S_AXIS_TREADY = (FIFO_COUNT != DEPTH) outside reset.
REQ-018 SHALL drive M_AXIS_TVALID = (FIFO_COUNT != 0); M_AXIS_TDATA and M_AXIS_TLAST SHALL be the head entry (first-word fall-through).
REQ-019 SHALL write on S_AXIS_TVALID && S_AXIS_TREADY and read on M_AXIS_TVALID && M_AXIS_TREADY.
REQ-020 SHALL present a word written on edge N as M_AXIS_TVALID after edge N when empty beforehand (1-cycle latency); it SHALL provide no combinational pass-through.
REQ-021 SHALL keep FIFO_COUNT unchanged on a simultaneous write and read, and SHALL change it by +1 or -1 on a write only or a read only.
REQ-022 SHALL block writes while full (TREADY is low), with no pass-through even if a read occurs in the same cycle; TREADY SHALL rise the cycle after the read.
REQ-023 SHALL wrap read and write pointers modulo DEPTH.
REQ-024 SHALL maintain an input index in_idx from 0 to FRAME_LEN-1 that increments per accepted word and wraps to 0 after FRAME_LEN-1.
REQ-025 SHALL store the tag (in_idx == FRAME_LEN-1) alongside each word and output it as M_AXIS_TLAST; downstream framing depends only on the word count.
REQ-026 SHALL set FRAME_ERR on an accepted word where S_AXIS_TLAST != (in_idx == FRAME_LEN-1); FRAME_ERR SHALL stay set until reset, and in_idx SHALL NOT resync on the error.
REQ-027 SHALL increment FRAME_CNT on each read with M_AXIS_TLAST=1, wrapping 0xFFFF to 0x0000.
REQ-028 SHALL hold M_AXIS_TDATA and M_AXIS_TLAST stable while M_AXIS_TVALID=1 and M_AXIS_TREADY=0.

Reset
REQ-029 SHALL, on an ACLK edge with ARESETN=0, clear the pointers, FIFO_COUNT, in_idx, FRAME_ERR and FRAME_CNT to 0.
REQ-030 SHALL drive S_AXIS_TREADY=0 and M_AXIS_TVALID=0 while ARESETN=0.
REQ-031 SHALL discard buffered words on reset mid-frame; the next accepted word SHALL be in_idx 0.
REQ-032 SHALL leave the storage array contents undefined after reset; they SHALL never be observable while M_AXIS_TVALID=0.

Structure
REQ-033 SHALL take DATA_WIDTH, FRAME_LEN and DEPTH defaults from shared package axis_frame_pkg, which is also used by the coprocessor and its bench.
REQ-034 SHALL place the storage (DEPTH x (DATA_WIDTH+1), one write port, asynchronous read) in sub-module axis_frame_fifo_mem; pointers, counters and flags SHALL stay in the top module.

Verification
REQ-035 SHALL cover: reset held 2 cycles -> all outputs 0; the first cycle after release -> S_AXIS_TREADY=1, FIFO_COUNT=0.
REQ-036 SHALL cover: 12 words 0x01..0x0C with TLAST on 0x0C, M_AXIS_TREADY=1 -> same 12 words in order, TLAST only with 0x0C, first M_AXIS_TVALID 1 cycle after the first accept, FRAME_CNT=1, FRAME_ERR=0.
REQ-037 SHALL cover: M_AXIS_TREADY=0 and 20 words offered -> 16 accepted, S_AXIS_TREADY low after the 16th, FIFO_COUNT=16; then drain -> 0x01..0x10 in order, TLAST on 0x0C only.
REQ-038 SHALL cover: S_AXIS_TLAST asserted on word 5 and not on word 12 -> FRAME_ERR=1 the next cycle; output TLAST still on word 12; FRAME_ERR remains 1 through the next correct frame.
REQ-039 SHALL cover: FIFO_COUNT=8 with both handshakes active for 10 cycles -> FIFO_COUNT stays 8 and output order is preserved across pointer wrap.
REQ-040 SHALL cover: reset after 5 words of a frame -> M_AXIS_TVALID=0 the next cycle; a following 12-word frame -> TLAST on its 12th word, FRAME_CNT=1.
